// File: rtl/bslfsr_pkg.sv
// Shared types and constants for the bit-swapping LFSR test-pattern generator.
// Imported by the swap network and the top-level generator.
package bslfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Legacy 8-bit feedback: s[0] ^ s[7]
  localparam logic [7:0] DEFAULT_TAPS = 8'h81;

endpackage

// File: rtl/bslfsr_swap.sv
// Combinational pair-swap network: exchanges (s[2k], s[2k+1]) below the control bit
// when enabled; the control bit and any unpaired bit pass straight through.
module bslfsr_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] s,
  input  logic             en,
  output logic [WIDTH-1:0] pattern
);

  // Pairs live strictly below the MSB control bit.
  localparam int NP = (WIDTH - 1) / 2;

  for (genvar k = 0; k < NP; k++) begin : g_pair
    assign pattern[2*k]   = en ? s[2*k+1] : s[2*k];
    assign pattern[2*k+1] = en ? s[2*k]   : s[2*k+1];
  end

  for (genvar i = 2*NP; i < WIDTH; i++) begin : g_pass
    assign pattern[i] = s[i];
  end

endmodule

// File: rtl/bslfsr_gen.sv
// Parametrised bit-swapping LFSR pattern generator with seed load, run-length control
// and a valid/ready output handshake.
module bslfsr_gen
  import bslfsr_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEFAULT_TAPS),
  parameter int               CNT_W      = 16,
  parameter logic [WIDTH-1:0] RESET_SEED = '1
) (
  input  logic             clk,
  input  logic             set,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             bs_en,
  input  logic [CNT_W-1:0] run_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             seed_err,
  output logic [CNT_W-1:0] count
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_shift;
  logic [WIDTH-1:0] load_val;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] cnt_inc;
  logic             fb;
  logic             accept;
  logic             last;
  logic             seed_zero;
  logic             idle_load;
  logic             idle_start;

  // Counter increments stick at all-ones so free-running runs never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}})
      return v;
    return v + CNT_W'(1);
  endfunction

  assign fb        = ^(s & TAPS);
  assign s_shift   = {s[WIDTH-2:0], fb};
  assign seed_zero = (seed == '0);
  assign load_val  = seed_zero ? RESET_SEED : seed;

  assign idle_load  = (state == IDLE) && load;
  assign idle_start = (state == IDLE) && start;
  assign accept     = (state == RUN) && out_ready;
  assign cnt_inc    = sat_inc(count);
  assign last       = accept && (len != '0) && (cnt_inc == len);

  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  bslfsr_swap #(
    .WIDTH(WIDTH)
  ) u_swap (
    .s      (s),
    .en     (bs_en & ~s[WIDTH-1]),
    .pattern(pattern)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = RUN;
      // stop wins over a completing accept: aborted runs never pulse done
      RUN: begin
        if (stop)      state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (set) begin
      state    <= IDLE;
      s        <= RESET_SEED;
      count    <= '0;
      len      <= '0;
      seed_err <= 1'b0;
    end else begin
      state <= state_nx;

      // A load coinciding with start seeds the run that starts in the same cycle.
      if (idle_load) begin
        s        <= load_val;
        seed_err <= seed_zero;
      end else if (accept) begin
        s <= s_shift;
      end

      if (idle_start) begin
        len   <= run_len;
        count <= '0;
      end else if (accept) begin
        count <= cnt_inc;
      end
    end
  end

endmodule

// File: doc/bslfsr_gen.md
Name: bslfsr_gen

Overview:
Parametrised bit-swapping LFSR test-pattern generator, the next generation of the fixed 8-bit BS-LFSR. It adds configurable width and taps, seed loading, runtime mode select between plain LFSR and bit-swap, run-length control, and a valid/ready output handshake. It sits between the TPG control logic and the scan/BIST pattern consumer.

Parameters:
WIDTH, 8, LFSR length in bits (>= 3).
TAPS, 8'h81, feedback mask; bit i=1 means stage s[i] is XORed into feedback (default = s[0]^s[7], legacy-compatible).
CNT_W, 16, width of run-length and pattern counter.
RESET_SEED, all ones, state loaded at reset and substituted for an all-zero seed.

Ports:
clk  in  1  clock; all logic on rising edge.
set  in  1  reset, synchronous, active-high.
start  in  1  begin a run (honoured in IDLE only).
stop  in  1  abort the current run.
load  in  1  load seed into state (honoured in IDLE only).
seed  in  WIDTH  seed value for load.
bs_en  in  1  1 = bit-swap output mode, 0 = plain LFSR output.
run_len  in  CNT_W  patterns per run, sampled at start; 0 = free-running.
out_ready  in  1  consumer accepts the pattern.
out_valid  out  1  pattern is valid.
pattern  out  WIDTH  current test pattern.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse when a run completes.
seed_err  out  1  sticky; set when an all-zero seed was loaded; cleared by set or next non-zero load.
count  out  CNT_W  patterns accepted in current or last run.

Behaviour:
- Reset (set=1 at clk edge): state s=RESET_SEED, FSM=IDLE, out_valid=0, busy=0, done=0, seed_err=0, count=0, latched run_len=0. Reset mid-run aborts immediately; no done pulse.
- Shift: on advance, s[i]<=s[i-1] for i>=1; s[0]<=XOR of s[i] where TAPS[i]=1.
- Output mapping: control bit c=s[WIDTH-1]. If bs_en=1 and c=0, swap pairs (s[2k],s[2k+1]) for all 2k+1<=WIDTH-2; the unpaired bit (odd WIDTH-1) and c pass through. Otherwise pattern=s. pattern is combinational from s and bs_en; bs_en may change at any time and takes effect in the same cycle.
- FSM: IDLE, RUN, DONE.
  - IDLE: out_valid=0. load=1: s<=seed, or RESET_SEED and seed_err<=1 if seed==0. start=1: latch run_len, count<=0, ->RUN. load and start in the same cycle: seed is applied and RUN begins with the new seed.
  - RUN: out_valid=1, busy=1. Advance (shift, count+1) only on out_valid&&out_ready; pattern and s stay stable while stalled. If the accept makes count==latched run_len (run_len!=0), ->DONE. stop=1 ->IDLE next cycle with no done; a simultaneous accept still counts and shifts. start and load are ignored.
  - DONE: done=1 for exactly one cycle, out_valid=0, ->IDLE. count holds its value until the next start.
- Latency: first pattern is valid the cycle after start; one pattern per cycle at full throughput.
- count saturates at all-ones in free-running mode and does not wrap; the LFSR keeps advancing.
- State never becomes all-zero, because zero seeds are substituted.

Decomposition:
- Package bslfsr_pkg: FSM state enum (IDLE/RUN/DONE) and the default-taps constant for WIDTH=8.
- Sub-module bslfsr_swap (param WIDTH): purely combinational pair-swap network taking s and the enable (bs_en & ~c).
- The top level holds the FSM, the shift register and the counter.

Test Plan:
- WIDTH=8, reset, start with run_len=9, bs_en=0, out_ready=1 -> patterns FF,FE,FD,FA,F5,EA,D5,AA,55; done pulses on the cycle after the 9th accept; count=9.
- Same run with bs_en=1 -> first 8 patterns unchanged (c=1); 9th pattern is 6A instead of 55.
- load with seed=00 -> state=FF and seed_err=1; then load with seed=A5 -> seed_err=0, and after start the first pattern is A5.
- Hold out_ready=0 for 5 cycles mid-run -> pattern and count are frozen and out_valid stays 1; the sequence resumes without skipping a value.
- stop asserted together with the 3rd accept -> count=3, FSM in IDLE next cycle, no done pulse; set asserted mid-run -> all outputs at reset values next cycle.
- run_len=0 with CNT_W=4 and 20 accepts -> count saturates at F, no done, and the LFSR sequence continues.
